// File: rtl/timing_pkg.sv
// Shared vertical-timing definitions for the clk74m pixel domain:
// line-number width, 720p raster height and the lock controller state encoding.
package timing_pkg;

  localparam int LINE_W      = 11;
  localparam int VTOTAL_720P = 750;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_ALIGN  = 3'd2,
    ST_LOCKED = 3'd3
  } lock_state_e;

endpackage

// File: rtl/frame_edge_det.sv
// Detects the start of a received frame: a valid line number lower than the
// previous valid one marks a wrap, reported one cycle later as frame_start.
module frame_edge_det
  import timing_pkg::*;
(
  input  logic              clk74m,
  input  logic              restart_n,
  input  logic              line_vld,
  input  logic [LINE_W-1:0] line_num,
  output logic              frame_start
);

  logic [LINE_W-1:0] last_num_q, last_num_d;
  logic              frame_start_q, frame_start_d;

  always_comb begin
    last_num_d    = line_vld ? line_num : last_num_q;
    // Strict compare: a repeated line number is not a wrap.
    frame_start_d = line_vld && (line_num < last_num_q);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the blocks are evaluated in.
  always_ff @(posedge clk74m or negedge restart_n) begin
    if (!restart_n) begin
      last_num_q    <= '0;
      frame_start_q <= 1'b0;
    end else begin
      last_num_q    <= last_num_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign frame_start = frame_start_q;

endmodule

// File: rtl/vsync_lock_ctrl.sv
// Frame-alignment controller: compares received frame starts with the local
// vertical count, pulses vclr until the raster agrees, then holds lock.
module vsync_lock_ctrl
  import timing_pkg::*;
#(
  parameter int LOCK_FRAMES   = 4,
  parameter int UNLOCK_MISSES = 3,
  parameter int WINDOW        = 2,
  parameter int VTOTAL        = VTOTAL_720P,
  parameter int WDOG_FRAMES   = 3
) (
  input  logic              clk74m,
  input  logic              restart_n,
  input  logic              enable,
  input  logic              line_vld,
  input  logic [LINE_W-1:0] line_num,
  input  logic [LINE_W-1:0] vcount,
  output logic              vclr,
  output logic              locked,
  output logic [2:0]        state,
  output logic [11:0]       phase_err,
  output logic [7:0]        resync_cnt
);

  localparam logic [11:0] HALF_VT  = 12'(VTOTAL / 2);
  localparam logic [11:0] VT_12    = 12'(VTOTAL);
  localparam logic [11:0] WIN_12   = 12'(WINDOW);
  localparam logic [3:0]  LOCK_N   = 4'(LOCK_FRAMES);
  localparam logic [3:0]  UNLOCK_N = 4'(UNLOCK_MISSES);
  localparam logic [3:0]  WDOG_N   = 4'(WDOG_FRAMES);

  lock_state_e       state_q, state_d;
  logic [3:0]        good_cnt_q, good_cnt_d;
  logic [3:0]        miss_cnt_q, miss_cnt_d;
  logic [3:0]        wdog_cnt_q, wdog_cnt_d;
  logic [LINE_W-1:0] prev_vcount_q;
  logic              vclr_q, vclr_d;
  logic [11:0]       phase_err_q, phase_err_d;
  logic [7:0]        resync_cnt_q, resync_cnt_d;

  logic        frame_start;
  logic        lwrap;
  logic        wdog_active;
  logic        in_window;
  logic [11:0] vc_ext, err, err_abs;

  frame_edge_det u_edge (
    .clk74m      (clk74m),
    .restart_n   (restart_n),
    .line_vld    (line_vld),
    .line_num    (line_num),
    .frame_start (frame_start)
  );

  assign lwrap = (vcount < prev_vcount_q);

  // Lines in the upper half of the raster are read as a negative (early) phase.
  always_comb begin
    vc_ext    = {1'b0, vcount};
    err       = (vc_ext < HALF_VT) ? vc_ext : (vc_ext - VT_12);
    err_abs   = err[11] ? (~err + 12'd1) : err;
    in_window = (err_abs <= WIN_12);
  end

  // NOTE: every signal written here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d      = state_q;
    good_cnt_d   = good_cnt_q;
    miss_cnt_d   = miss_cnt_q;
    wdog_cnt_d   = '0;
    vclr_d       = 1'b0;
    phase_err_d  = phase_err_q;
    wdog_active  = (state_q == ST_ALIGN) || (state_q == ST_LOCKED);

    if (wdog_active) begin
      if (frame_start)  wdog_cnt_d = '0;
      else if (lwrap)   wdog_cnt_d = wdog_cnt_q + 4'd1;
      else              wdog_cnt_d = wdog_cnt_q;
    end

    if (frame_start && (state_q != ST_IDLE)) phase_err_d = err;

    unique case (state_q)
      ST_IDLE: begin
        if (enable) state_d = ST_SEARCH;
      end
      ST_SEARCH: begin
        if (frame_start) begin
          vclr_d     = 1'b1;
          good_cnt_d = '0;
          state_d    = ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        if (frame_start) begin
          if (!in_window) begin
            vclr_d     = 1'b1;
            good_cnt_d = '0;
          end else if (good_cnt_q + 4'd1 == LOCK_N) begin
            state_d    = ST_LOCKED;
            good_cnt_d = '0;
            miss_cnt_d = '0;
          end else begin
            good_cnt_d = good_cnt_q + 4'd1;
          end
        end
      end
      ST_LOCKED: begin
        if (frame_start) begin
          if (in_window) begin
            miss_cnt_d = '0;
          end else if (miss_cnt_q + 4'd1 == UNLOCK_N) begin
            state_d    = ST_SEARCH;
            miss_cnt_d = '0;
          end else begin
            miss_cnt_d = miss_cnt_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Incoming frames have stopped: re-search without disturbing the raster.
    if (wdog_active && (wdog_cnt_d == WDOG_N)) begin
      state_d    = ST_SEARCH;
      vclr_d     = 1'b0;
      good_cnt_d = '0;
      miss_cnt_d = '0;
      wdog_cnt_d = '0;
    end

    if (!enable) begin
      state_d     = ST_IDLE;
      vclr_d      = 1'b0;
      good_cnt_d  = '0;
      miss_cnt_d  = '0;
      wdog_cnt_d  = '0;
      phase_err_d = phase_err_q;
    end

    resync_cnt_d = (vclr_d && (resync_cnt_q != 8'hFF)) ? resync_cnt_q + 8'd1 : resync_cnt_q;
  end

  always_ff @(posedge clk74m or negedge restart_n) begin
    if (!restart_n) begin
      state_q       <= ST_IDLE;
      good_cnt_q    <= '0;
      miss_cnt_q    <= '0;
      wdog_cnt_q    <= '0;
      prev_vcount_q <= '0;
      vclr_q        <= 1'b0;
      phase_err_q   <= '0;
      resync_cnt_q  <= '0;
    end else begin
      state_q       <= state_d;
      good_cnt_q    <= good_cnt_d;
      miss_cnt_q    <= miss_cnt_d;
      wdog_cnt_q    <= wdog_cnt_d;
      prev_vcount_q <= vcount;
      vclr_q        <= vclr_d;
      phase_err_q   <= phase_err_d;
      resync_cnt_q  <= resync_cnt_d;
    end
  end

  assign vclr       = vclr_q;
  assign locked     = (state_q == ST_LOCKED);
  assign state      = state_q;
  assign phase_err  = phase_err_q;
  assign resync_cnt = resync_cnt_q;

endmodule

// File: tb/tb_vsync_lock_ctrl.sv
// Directed bench for vsync_lock_ctrl: a line stream and a local raster counter
// that the bench clears whenever vclr is seen, with hand-derived expectations.
module tb_vsync_lock_ctrl;

  localparam int VT = 750;

  logic        clk74m;
  logic        restart_n;
  logic        enable;
  logic        line_vld;
  logic [10:0] line_num;
  logic [10:0] vcount;
  logic        vclr;
  logic        locked;
  logic [2:0]  state;
  logic [11:0] phase_err;
  logic [7:0]  resync_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Environment: received line counter and local raster counter.
  int rx = 0, loc = 0, last_rx = 0, last_loc = 0;
  bit rx_on = 0;
  bit wrap_drv = 0, lwrap_drv = 0;
  int vclr_seen = 0;

  vsync_lock_ctrl dut (
    .clk74m     (clk74m),
    .restart_n  (restart_n),
    .enable     (enable),
    .line_vld   (line_vld),
    .line_num   (line_num),
    .vcount     (vcount),
    .vclr       (vclr),
    .locked     (locked),
    .state      (state),
    .phase_err  (phase_err),
    .resync_cnt (resync_cnt)
  );

  initial clk74m = 1'b0;
  always #5 clk74m = ~clk74m;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: drive the stream and raster, then look at outputs 1 ns after the edge.
  task automatic run_cycle();
    line_vld  = rx_on;
    line_num  = 11'(rx);
    vcount    = 11'(loc);
    wrap_drv  = rx_on && (rx == 0) && (last_rx == VT - 1);
    lwrap_drv = (loc < last_loc);
    if (rx_on) last_rx = rx;
    last_loc = loc;
    @(posedge clk74m);
    #1;
    if (vclr) vclr_seen++;
    if (rx_on) rx = (rx + 1) % VT;
    loc = vclr ? 0 : (loc + 1) % VT;
  endtask

  // Returns in the cycle where frame_start is expected (one after the wrap).
  task automatic goto_wrap();
    int n = 0;
    do begin
      run_cycle();
      n++;
    end while (!wrap_drv && n < 2 * VT);
    vectors++;
    if (!wrap_drv) begin
      miscompares++;
      $display("FAIL wrap_budget: no line wrap within %0d cycles", n);
    end
  endtask

  // Place the local raster so the next frame start sees an error of e lines.
  task automatic set_phase(input int e);
    loc = (((rx + e - 1) % VT) + VT) % VT;
  endtask

  task automatic drive_raw(input logic vld, input int num, input int vc);
    line_vld = vld;
    line_num = 11'(num);
    vcount   = 11'(vc);
    @(posedge clk74m);
    #1;
    if (vclr) vclr_seen++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int lw, early, n, seen0;

    restart_n = 1'b0;
    enable    = 1'b0;
    line_vld  = 1'b0;
    line_num  = '0;
    vcount    = '0;
    repeat (3) @(posedge clk74m);
    #1;
    check("rst_state",     32'(state),      32'd0);
    check("rst_vclr",      32'(vclr),       32'd0);
    check("rst_locked",    32'(locked),     32'd0);
    check("rst_phase_err", 32'(phase_err),  32'd0);
    check("rst_resync",    32'(resync_cnt), 32'd0);

    // Stream runs while disabled; nothing may happen.
    restart_n = 1'b1;
    rx_on = 1;
    loc   = 100;
    repeat (5) run_cycle();
    check("idle_hold",    32'(state),     32'd0);
    check("idle_no_vclr", 32'(vclr_seen), 32'd0);
    enable = 1'b1;
    run_cycle();
    check("idle_to_search", 32'(state), 32'd1);

    // Acquire: first wrap clears the raster, then four in-window frames.
    goto_wrap();
    check("acq_pre_vclr", 32'(vclr), 32'd0);
    run_cycle();
    check("acq_vclr",   32'(vclr),       32'd1);
    check("acq_align",  32'(state),      32'd2);
    run_cycle();
    check("acq_vclr_1cyc", 32'(vclr), 32'd0);
    for (int i = 0; i < 4; i++) begin
      goto_wrap();
      run_cycle();
      check("acq_state", 32'(state), (i < 3) ? 32'd2 : 32'd3);
    end
    check("acq_locked",    32'(locked),     32'd1);
    check("acq_phase_err", 32'(phase_err),  32'hFFF);
    check("acq_resync",    32'(resync_cnt), 32'd1);

    // Window edge: +2 holds lock, -3 three times drops to search.
    set_phase(2);
    for (int i = 0; i < 3; i++) begin
      goto_wrap();
      run_cycle();
      check("win_p2_state", 32'(state),     32'd3);
      check("win_p2_err",   32'(phase_err), 32'd2);
    end
    set_phase(-3);
    for (int i = 0; i < 3; i++) begin
      goto_wrap();
      run_cycle();
      check("win_m3_state", 32'(state), (i < 2) ? 32'd3 : 32'd1);
    end
    check("win_m3_locked", 32'(locked),    32'd0);
    check("win_m3_err",    32'(phase_err), 32'hFFD);
    check("win_m3_vclr",   32'(vclr),      32'd0);

    // Reacquire, then starve the controller of frames.
    goto_wrap();
    run_cycle();
    check("reacq_vclr", 32'(vclr), 32'd1);
    for (int i = 0; i < 4; i++) begin
      goto_wrap();
      run_cycle();
    end
    check("reacq_state",  32'(state),      32'd3);
    check("reacq_resync", 32'(resync_cnt), 32'd2);

    rx_on = 0;
    lw = 0; early = 0; n = 0;
    seen0 = vclr_seen;
    while (lw < 3 && n < 4 * VT) begin
      run_cycle();
      n++;
      if (lwrap_drv) lw++;
      if (lw < 3 && state != 3'd3) early++;
    end
    check("wdog_lwraps", 32'(lw),        32'd3);
    check("wdog_early",  32'(early),     32'd0);
    check("wdog_state",  32'(state),     32'd1);
    check("wdog_locked", 32'(locked),    32'd0);
    check("wdog_novclr", 32'(vclr_seen), 32'(seen0));

    // Realign: two good frames, a +40 miss, then four more good frames.
    rx_on = 1;
    goto_wrap();
    run_cycle();
    check("realign_acq", 32'(state), 32'd2);
    for (int i = 0; i < 2; i++) begin
      goto_wrap();
      run_cycle();
      check("realign_good", 32'(state), 32'd2);
    end
    set_phase(40);
    goto_wrap();
    run_cycle();
    check("realign_vclr",   32'(vclr),       32'd1);
    check("realign_state",  32'(state),      32'd2);
    check("realign_err",    32'(phase_err),  32'h028);
    check("realign_resync", 32'(resync_cnt), 32'd4);
    for (int i = 0; i < 4; i++) begin
      goto_wrap();
      run_cycle();
      check("realign_relock", 32'(state), (i < 3) ? 32'd2 : 32'd3);
    end

    // Disable in the frame_start cycle: IDLE wins, no vclr, phase_err holds.
    set_phase(1);
    goto_wrap();
    enable = 1'b0;
    run_cycle();
    check("prio_state",  32'(state),      32'd0);
    check("prio_vclr",   32'(vclr),       32'd0);
    check("prio_locked", 32'(locked),     32'd0);
    check("prio_err",    32'(phase_err),  32'hFFF);
    check("prio_resync", 32'(resync_cnt), 32'd4);

    enable = 1'b1;
    rx_on  = 0;
    run_cycle();
    check("reenable_state", 32'(state), 32'd1);

    // Repeated line numbers are not a wrap.
    seen0 = vclr_seen;
    repeat (4) drive_raw(1'b1, 5, 100);
    repeat (2) drive_raw(1'b0, 5, 100);
    check("equal_state",  32'(state),     32'd1);
    check("equal_novclr", 32'(vclr_seen), 32'(seen0));

    // Saturation: 300 back-to-back wraps, each out of window.
    seen0 = vclr_seen;
    for (int i = 0; i < 300; i++) begin
      drive_raw(1'b1, 0, 100);
      drive_raw(1'b1, 1, 100);
    end
    repeat (3) drive_raw(1'b0, 0, 100);
    check("sat_pulses", 32'(vclr_seen - seen0), 32'd300);
    check("sat_resync", 32'(resync_cnt),        32'd255);
    check("sat_state",  32'(state),             32'd2);
    check("sat_err",    32'(phase_err),         32'h064);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
